// File: rtl/cache_pkg.sv
// Shared cache/refill types: address field widths, refill FSM states
// and tag/index/offset field extraction helpers.
package cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } refill_state_t;

    function automatic logic [TAG_W-1:0] get_tag(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(
        input logic [ADDR_W-1:0] a
    );
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] get_offset(
        input logic [ADDR_W-1:0] a
    );
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/mem_refill_engine_if.sv
// Controller-side request/response and data-memory bus of the refill engine.
// master = controller plus memory, slave = refill engine.
interface mem_refill_engine_if #(
    parameter int ADDR_W          = cache_pkg::ADDR_W,
    parameter int DATA_W          = cache_pkg::DATA_W,
    parameter int WORDS_PER_BLOCK = 4
);

    logic                              MemRead;
    logic                              MemWrite;
    logic                              CounterEn;
    logic [ADDR_W-1:0]                 Address;
    logic [DATA_W-1:0]                 WriteData;
    logic                              Ready;
    logic [DATA_W*WORDS_PER_BLOCK-1:0] FillData;
    logic [ADDR_W-1:0]                 MemAddr;
    logic                              MemRE;
    logic [DATA_W-1:0]                 MemRData;
    logic                              MemWE;
    logic [DATA_W-1:0]                 MemWData;

    modport master (
        output MemRead, MemWrite, CounterEn, Address, WriteData, MemRData,
        input  Ready, FillData, MemAddr, MemRE, MemWE, MemWData
    );

    modport slave (
        input  MemRead, MemWrite, CounterEn, Address, WriteData, MemRData,
        output Ready, FillData, MemAddr, MemRE, MemWE, MemWData
    );

endinterface

// File: rtl/refill_cycle_counter.sv
// Transaction cycle counter: clears on accept, counts while busy,
// saturates at LIMIT; last flags the final busy cycle (LIMIT-1).
module refill_cycle_counter #(
    parameter int CW    = 3,
    parameter int LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != CW'(LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_refill_engine.sv
// Memory-side refill/write-through sequencer behind the cache controller.
// Define REFILL_CRITICAL_WORD_FIRST_EN to fetch the requested word first.
module mem_refill_engine
    import cache_pkg::*;
#(
    parameter int ADDR_W          = cache_pkg::ADDR_W,
    parameter int DATA_W          = cache_pkg::DATA_W,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              CLK,
    input  logic              RST,
    mem_refill_engine_if.slave bus
);

    localparam int OW = $clog2(WORDS_PER_BLOCK);
    localparam int BW = ADDR_W - OW;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] NWORDS = CW'(WORDS_PER_BLOCK);

    if (WORDS_PER_BLOCK < 2 ||
        (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_wpb
        $error("WORDS_PER_BLOCK must be a power of 2 and >= 2");
    end
    if (MEM_LATENCY < WORDS_PER_BLOCK) begin : g_bad_lat
        $error("MEM_LATENCY must be >= WORDS_PER_BLOCK");
    end

    refill_state_t                     state_q;
    logic [BW-1:0]                     blk_q;
    logic [ADDR_W-1:0]                 addr_q;
    logic [DATA_W-1:0]                 wdata_q;
    logic                              ready_q;
    logic                              re_q;
    logic                              we_q;
    logic [DATA_W*WORDS_PER_BLOCK-1:0] fill_q;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          last;
    logic          accept;
    logic          more_rd;
    logic [OW-1:0] first_w;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    logic [OW-1:0] off_q;
    assign first_w = bus.Address[OW-1:0];

    // Offset-relative word order wraps past the block end.
    function automatic logic [OW-1:0] word_of(input logic [OW-1:0] c);
        return off_q + c;
    endfunction
`else
    assign first_w = '0;

    function automatic logic [OW-1:0] word_of(input logic [OW-1:0] c);
        return c;
    endfunction
`endif

    assign accept  = (state_q == IDLE) && bus.CounterEn &&
                     (bus.MemRead || bus.MemWrite);
    assign cnt_nx  = cnt + CW'(1);
    assign more_rd = (cnt_nx < NWORDS);

    refill_cycle_counter #(
        .CW   (CW),
        .LIMIT(MEM_LATENCY)
    ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr_i (accept),
        .en_i  (state_q != IDLE),
        .cnt_o (cnt),
        .last_o(last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            blk_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            fill_q  <= '0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
            off_q   <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.CounterEn && bus.MemRead) begin
                        state_q <= RD;
                        blk_q   <= bus.Address[ADDR_W-1:OW];
                        addr_q  <= {bus.Address[ADDR_W-1:OW], first_w};
                        re_q    <= 1'b1;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
                        off_q   <= bus.Address[OW-1:0];
`endif
                    end else if (bus.CounterEn && bus.MemWrite) begin
                        state_q <= WR;
                        addr_q  <= bus.Address;
                        wdata_q <= bus.WriteData;
                        we_q    <= 1'b1;
                    end
                end
                RD: begin
                    if (re_q) begin
                        fill_q[DATA_W*int'(word_of(cnt[OW-1:0])) +: DATA_W]
                            <= bus.MemRData;
                    end
                    re_q <= more_rd;
                    if (more_rd) begin
                        addr_q <= {blk_q, word_of(cnt_nx[OW-1:0])};
                    end
                    if (last) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                WR: begin
                    if (last) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Ready    = ready_q;
    assign bus.FillData = fill_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemRE    = re_q;
    assign bus.MemWE    = we_q;
    assign bus.MemWData = wdata_q;

endmodule
